map_frame_buffer: RTL and testbench
===================================

// Module: map_frame_buffer
// PURPOSE
//  Double-buffered tile map feeding draw.map. Game logic writes tiles into a
//  shadow map through a valid/ready port, then commits. The shadow map is copied
//  to the displayed map only at the start of vertical blanking, so draw never
//  renders a half-updated frame. Sits between the game engine and draw.
// PARAMETERS
//  MAP_W   32  tile columns; equals the snake_pkg map width
//  MAP_H   24  tile rows; equals the snake_pkg map height
//  COORD_B 6   width of the wr_x / wr_y coordinate ports
// PORTS
//  clk       in   1        pixel clock, 75 MHz, shared with vga_timing/draw
//  rst       in   1        asynchronous, active-high reset
//  vblnk     in   1        vertical blank from vga_timing (vga.vblnk)
//  wr_valid  in   1        tile write request
//  wr_ready  out  1        block accepts a write this cycle
//  wr_x      in   COORD_B  column, 0..MAP_W-1
//  wr_y      in   COORD_B  row, 0..MAP_H-1
//  wr_tile   in   RGB-free snake_pkg tile code (EMPTY/WALL/SNAKE1/SNAKE2/POINT)
//  clear     in   1        pulse: fill the shadow map with EMPTY
//  commit    in   1        pulse: publish the shadow map at the next vblank start
//  map       out  map_s    displayed map, tiles[row][col], to draw
//  swapped   out  1        1-cycle pulse after map was updated
//  wr_err    out  1        1-cycle pulse: accepted write had an out-of-range coord
//  busy      out  1        state != IDLE
// BEHAVIOUR
//  Reset: map and shadow all EMPTY, state IDLE, wr_ready=1, swapped=0,
//   wr_err=0, busy=0, vblnk_d=0, commit_q=0. Reset mid-operation aborts any
//   clear or pending swap. Nothing is published.
//  wr_ready = (state==IDLE). Transfer = wr_valid & wr_ready. On that edge
//   shadow[wr_y][wr_x] <= wr_tile. Out-of-range x or y: the write is accepted
//   and dropped, and wr_err pulses in the next cycle.
//  FSM IDLE/CLEAR/PENDING:
//   IDLE: clear -> CLEAR (cnt=0). Otherwise commit -> PENDING.
//    clear and commit together: CLEAR, and commit_q<=1.
//    A transfer in the same cycle as commit is included in the commit.
//   CLEAR: write EMPTY to one tile per cycle in raster order (cnt=row*MAP_W+col).
//    Takes exactly MAP_W*MAP_H cycles. At the last tile: commit_q ? PENDING : IDLE,
//    then commit_q<=0. A commit during CLEAR sets commit_q. A clear during CLEAR is ignored.
//   PENDING: vblnk_d <= vblnk every cycle. When vblnk & ~vblnk_d: map <= shadow
//    (all tiles on one edge), state -> IDLE, swapped=1 in the next cycle.
//    If vblnk is already high when PENDING is entered, wait for the next frame's
//    rising edge. clear and commit are ignored in PENDING.
//  map changes only on a swap edge. The shadow map is never visible directly.
//  After a swap the shadow keeps its contents, so incremental updates are allowed.
// TESTING
//  1 reset -> all map tiles EMPTY, wr_ready=1, busy=0, swapped=0.
//  2 write (1,1)=WALL, (2,1)=SNAKE1, commit with vblnk low -> map unchanged until
//    vblnk rises. Then map.tiles[1][1]=WALL and map.tiles[1][2]=SNAKE1, and
//    swapped pulses for exactly 1 cycle.
//  3 commit while vblnk already high -> no swap this frame. The swap happens at
//    the next vblnk rise, and wr_ready=0 for the whole wait.
//  4 clear+commit together with tiles set -> wr_ready=0 for MAP_W*MAP_H cycles,
//    then PENDING. After vblnk rises, all map tiles are EMPTY.
//  5 write with wr_x=MAP_W -> wr_err=1 for 1 cycle, and no tile changes after commit.
//  6 assert rst during PENDING -> map EMPTY, state IDLE, no swapped pulse.

Source files
------------

// File: rtl/map_frame_buffer.sv
// ============================================================================
// Module      : map_frame_buffer
// Description : Double-buffered tile map. Writes land in a shadow map; a
//               commit publishes it to the displayed map at vblank start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module map_frame_buffer #(
   parameter int MAP_W   = 32,
   parameter int MAP_H   = 24,
   parameter int COORD_B = 6,
   parameter int TILE_B  = 3
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     vblnk,
   input  logic                                     wr_valid,
   output logic                                     wr_ready,
   input  logic [COORD_B-1:0]                       wr_x,
   input  logic [COORD_B-1:0]                       wr_y,
   input  logic [TILE_B-1:0]                        wr_tile,
   input  logic                                     clear,
   input  logic                                     commit,
   output logic [MAP_H-1:0][MAP_W-1:0][TILE_B-1:0]  map,
   output logic                                     swapped,
   output logic                                     wr_err,
   output logic                                     busy
);

   localparam int c_XB = $clog2(MAP_W);
   localparam int c_YB = $clog2(MAP_H);

   localparam logic [TILE_B-1:0]  c_EMPTY    = '0;
   localparam logic [COORD_B:0]   c_X_LIM    = (COORD_B+1)'(MAP_W);
   localparam logic [COORD_B:0]   c_Y_LIM    = (COORD_B+1)'(MAP_H);
   localparam logic [c_XB-1:0]    c_COL_LAST = c_XB'(MAP_W - 1);
   localparam logic [c_YB-1:0]    c_ROW_LAST = c_YB'(MAP_H - 1);

   localparam logic [1:0] c_IDLE    = 2'd0;
   localparam logic [1:0] c_CLEAR   = 2'd1;
   localparam logic [1:0] c_PENDING = 2'd2;

   logic [1:0]        r_state;
   logic [c_YB-1:0]   r_row;
   logic [c_XB-1:0]   r_col;
   logic              r_commit_q;
   logic              r_vblnk_d;
   logic              r_swapped;
   logic              r_wr_err;

   logic              w_idle;
   logic              w_xfer;
   logic              w_in_range;
   logic              w_wr_en;
   logic              w_clr_en;
   logic              w_last;
   logic              w_vb_rise;
   logic              w_swap;
   logic [c_XB-1:0]   w_wx;
   logic [c_YB-1:0]   w_wy;

   assign w_idle     = (r_state == c_IDLE);
   assign wr_ready   = w_idle;
   assign busy       = ~w_idle;
   assign swapped    = r_swapped;
   assign wr_err     = r_wr_err;

   assign w_xfer     = wr_valid & w_idle;
   assign w_in_range = ({1'b0, wr_x} < c_X_LIM) & ({1'b0, wr_y} < c_Y_LIM);
   assign w_wr_en    = w_xfer & w_in_range;
   assign w_wx       = wr_x[c_XB-1:0];
   assign w_wy       = wr_y[c_YB-1:0];

   assign w_clr_en   = (r_state == c_CLEAR);
   assign w_last     = w_clr_en & (r_row == c_ROW_LAST) & (r_col == c_COL_LAST);
   // vblnk_d tracks vblnk in every state, so a vblank already in progress
   // when PENDING is entered is never mistaken for a rising edge.
   assign w_vb_rise  = vblnk & ~r_vblnk_d;
   assign w_swap     = (r_state == c_PENDING) & w_vb_rise;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= c_IDLE;
         r_row      <= '0;
         r_col      <= '0;
         r_commit_q <= 1'b0;
         r_vblnk_d  <= 1'b0;
         r_swapped  <= 1'b0;
         r_wr_err   <= 1'b0;
      end else begin
         r_vblnk_d <= vblnk;
         r_swapped <= w_swap;
         r_wr_err  <= w_xfer & ~w_in_range;
         case (r_state)
            c_IDLE: begin
               if (clear) begin
                  r_state    <= c_CLEAR;
                  r_row      <= '0;
                  r_col      <= '0;
                  r_commit_q <= commit;
               end else if (commit) begin
                  r_state <= c_PENDING;
               end
            end
            c_CLEAR: begin
               if (commit) begin
                  r_commit_q <= 1'b1;
               end
               if (r_col == c_COL_LAST) begin
                  r_col <= '0;
                  r_row <= r_row + c_YB'(1);
               end else begin
                  r_col <= r_col + c_XB'(1);
               end
               // A commit arriving on the final clear cycle still counts.
               if (w_last) begin
                  r_state    <= (r_commit_q | commit) ? c_PENDING : c_IDLE;
                  r_commit_q <= 1'b0;
               end
            end
            c_PENDING: begin
               if (w_vb_rise) begin
                  r_state <= c_IDLE;
               end
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   for (genvar gr = 0; gr < MAP_H; gr++) begin : g_row
      for (genvar gc = 0; gc < MAP_W; gc++) begin : g_col
         logic              w_hit_wr;
         logic              w_hit_clr;
         logic [TILE_B-1:0] r_shadow;
         logic [TILE_B-1:0] r_disp;

         assign w_hit_wr  = w_wr_en & (w_wy == c_YB'(gr)) & (w_wx == c_XB'(gc));
         assign w_hit_clr = w_clr_en & (r_row == c_YB'(gr)) & (r_col == c_XB'(gc));

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_shadow <= c_EMPTY;
            end else if (w_hit_clr) begin
               r_shadow <= c_EMPTY;
            end else if (w_hit_wr) begin
               r_shadow <= wr_tile;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_disp <= c_EMPTY;
            end else if (w_swap) begin
               r_disp <= r_shadow;
            end
         end

         assign map[gr][gc] = r_disp;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_map_frame_buffer.sv
// Testbench for map_frame_buffer: table-driven writes plus directed sequences
// for commit, vblank timing, clear length and reset abort.
`default_nettype none

module tb_map_frame_buffer;

   localparam int MAP_W   = 32;
   localparam int MAP_H   = 24;
   localparam int COORD_B = 6;
   localparam int TILE_B  = 3;

   localparam logic [2:0] EMPTY  = 3'd0;
   localparam logic [2:0] WALL   = 3'd1;
   localparam logic [2:0] SNAKE1 = 3'd2;
   localparam logic [2:0] SNAKE2 = 3'd3;
   localparam logic [2:0] POINT  = 3'd4;

   logic                                     clk = 1'b0;
   logic                                     rst;
   logic                                     vblnk;
   logic                                     wr_valid;
   logic                                     wr_ready;
   logic [COORD_B-1:0]                       wr_x;
   logic [COORD_B-1:0]                       wr_y;
   logic [TILE_B-1:0]                        wr_tile;
   logic                                     clear;
   logic                                     commit;
   logic [MAP_H-1:0][MAP_W-1:0][TILE_B-1:0]  map;
   logic                                     swapped;
   logic                                     wr_err;
   logic                                     busy;

   typedef struct {
      logic [COORD_B-1:0] x;
      logic [COORD_B-1:0] y;
      logic [TILE_B-1:0]  tile;
      logic               err;
   } vec_t;

   vec_t vecs [7];

   logic [2:0] sh   [MAP_H][MAP_W];
   logic [2:0] disp [MAP_H][MAP_W];

   int checks = 0;
   int errors = 0;
   int bad;
   int n;

   map_frame_buffer #(
      .MAP_W   (MAP_W),
      .MAP_H   (MAP_H),
      .COORD_B (COORD_B),
      .TILE_B  (TILE_B)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .vblnk    (vblnk),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_x     (wr_x),
      .wr_y     (wr_y),
      .wr_tile  (wr_tile),
      .clear    (clear),
      .commit   (commit),
      .map      (map),
      .swapped  (swapped),
      .wr_err   (wr_err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_map(input string name);
      int diffs = 0;
      int fr = 0;
      int fc = 0;
      logic [2:0] fa = '0;
      logic [2:0] fe = '0;
      for (int r = 0; r < MAP_H; r++) begin
         for (int c = 0; c < MAP_W; c++) begin
            if (map[r][c] !== disp[r][c]) begin
               if (diffs == 0) begin
                  fr = r; fc = c; fa = map[r][c]; fe = disp[r][c];
               end
               diffs++;
            end
         end
      end
      checks++;
      if (diffs != 0) begin
         errors++;
         $display("FAIL %s %0d tiles differ, first [%0d][%0d] actual=%0d required=%0d",
                  name, diffs, fr, fc, fa, fe);
      end
   endtask

   task automatic model_reset;
      for (int r = 0; r < MAP_H; r++)
         for (int c = 0; c < MAP_W; c++) begin
            sh[r][c]   = EMPTY;
            disp[r][c] = EMPTY;
         end
   endtask

   task automatic model_clear_shadow;
      for (int r = 0; r < MAP_H; r++)
         for (int c = 0; c < MAP_W; c++)
            sh[r][c] = EMPTY;
   endtask

   task automatic model_publish;
      for (int r = 0; r < MAP_H; r++)
         for (int c = 0; c < MAP_W; c++)
            disp[r][c] = sh[r][c];
   endtask

   task automatic write_tile(input int x, input int y, input logic [2:0] t);
      wr_x     = COORD_B'(x);
      wr_y     = COORD_B'(y);
      wr_tile  = t;
      wr_valid = 1'b1;
      tick;
      wr_valid = 1'b0;
      if (x < MAP_W && y < MAP_H) sh[y][x] = t;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; vblnk = 1'b0; wr_valid = 1'b0; wr_x = '0; wr_y = '0;
      wr_tile = '0; clear = 1'b0; commit = 1'b0;

      vecs[0] = '{x: 6'd1,  y: 6'd1,  tile: WALL,   err: 1'b0};
      vecs[1] = '{x: 6'd2,  y: 6'd1,  tile: SNAKE1, err: 1'b0};
      vecs[2] = '{x: 6'd0,  y: 6'd0,  tile: SNAKE2, err: 1'b0};
      vecs[3] = '{x: 6'd32, y: 6'd0,  tile: POINT,  err: 1'b1};
      vecs[4] = '{x: 6'd1,  y: 6'd33, tile: SNAKE2, err: 1'b1};
      vecs[5] = '{x: 6'd31, y: 6'd23, tile: POINT,  err: 1'b0};
      vecs[6] = '{x: 6'd63, y: 6'd63, tile: WALL,   err: 1'b1};

      model_reset();
      repeat (3) tick;
      rst = 1'b0;
      tick;

      // Reset state
      chk_map("reset_map");
      chk("reset_wr_ready", wr_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_swapped", swapped, 0);
      chk("reset_wr_err", wr_err, 0);

      // Table-driven writes, including out-of-range coordinates
      for (int i = 0; i < 7; i++) begin
         write_tile(int'(vecs[i].x), int'(vecs[i].y), vecs[i].tile);
         chk($sformatf("wr_err[%0d]", i), wr_err, vecs[i].err);
         tick;
         chk($sformatf("wr_err_drop[%0d]", i), wr_err, 0);
      end
      chk_map("map_before_commit");

      // Commit with vblnk low: hold until the vblnk rise
      commit = 1'b1;
      tick;
      commit = 1'b0;
      chk("pending_busy", busy, 1);
      chk("pending_wr_ready", wr_ready, 0);
      repeat (5) tick;
      chk_map("map_held_pending");
      chk("no_early_swap", swapped, 0);
      vblnk = 1'b1;
      tick;
      model_publish();
      chk_map("map_after_swap");
      chk("swapped_pulse", swapped, 1);
      chk("tile_1_1_wall", map[1][1], WALL);
      chk("tile_1_2_snake1", map[1][2], SNAKE1);
      chk("idle_after_swap", wr_ready, 1);
      tick;
      chk("swapped_one_cycle", swapped, 0);

      // Commit while vblnk is already high, with a same-cycle write
      wr_x = 6'd6; wr_y = 6'd6; wr_tile = WALL; wr_valid = 1'b1; commit = 1'b1;
      tick;
      wr_valid = 1'b0; commit = 1'b0;
      sh[6][6] = WALL;
      bad = 0;
      repeat (10) begin
         if (wr_ready !== 1'b0 || swapped !== 1'b0) bad++;
         tick;
      end
      vblnk = 1'b0;
      repeat (10) begin
         if (wr_ready !== 1'b0 || swapped !== 1'b0) bad++;
         tick;
      end
      chk("wait_next_frame", bad, 0);
      chk_map("map_held_frame");
      vblnk = 1'b1;
      tick;
      model_publish();
      chk("swapped_next_frame", swapped, 1);
      chk_map("map_next_frame");
      chk("tile_6_6_same_cycle", map[6][6], WALL);

      // clear + commit together; vblnk rises on exactly the last clear cycle
      vblnk = 1'b0;
      tick;
      clear = 1'b1; commit = 1'b1;
      tick;
      clear = 1'b0; commit = 1'b0;
      chk("clear_wr_ready", wr_ready, 0);
      repeat (MAP_W*MAP_H - 1) tick;
      vblnk = 1'b1;
      tick;
      chk("no_swap_during_clear", swapped, 0);
      chk_map("map_during_clear");
      chk("pending_after_clear", wr_ready, 0);
      vblnk = 1'b0;
      tick;
      vblnk = 1'b1;
      tick;
      model_clear_shadow();
      model_publish();
      chk("swapped_after_clear", swapped, 1);
      chk_map("map_cleared");

      // Clear alone: measure its length, then publish the result
      vblnk = 1'b0;
      write_tile(7, 8, POINT);
      clear = 1'b1;
      tick;
      clear = 1'b0;
      n = 0;
      while (!wr_ready && n < 2000) begin
         n++;
         tick;
      end
      chk("clear_cycles", n, MAP_W*MAP_H);
      model_clear_shadow();
      commit = 1'b1;
      tick;
      commit = 1'b0;
      vblnk = 1'b1;
      tick;
      model_publish();
      chk_map("map_after_clear_only");

      // Reset during PENDING aborts the swap
      vblnk = 1'b0;
      write_tile(3, 3, WALL);
      commit = 1'b1;
      tick;
      commit = 1'b0;
      vblnk = 1'b1;
      tick;
      model_publish();
      chk_map("map_pre_reset");
      vblnk = 1'b0;
      write_tile(4, 4, POINT);
      commit = 1'b1;
      tick;
      commit = 1'b0;
      chk("busy_before_reset", busy, 1);
      rst = 1'b1;
      #2;
      model_reset();
      chk_map("map_async_reset");
      chk("reset_idle_ready", wr_ready, 1);
      chk("reset_idle_busy", busy, 0);
      tick;
      rst = 1'b0;
      tick;
      vblnk = 1'b1;
      bad = 0;
      repeat (4) begin
         tick;
         if (swapped !== 1'b0) bad++;
      end
      chk("no_swap_after_reset", bad, 0);
      chk_map("map_empty_after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
